// File: rtl/d_memory_arbiter_pkg.sv
// d_memory_arbiter_pkg: shared widths and FSM state encoding for the d_memory arbiter
package d_memory_arbiter_pkg;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;
endpackage

// File: rtl/d_memory_arbiter.sv
// d_memory_arbiter: shares d_memory between the core data port and a debug host, core first
module d_memory_arbiter
  import d_memory_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  input  logic          core_write_i,
  input  logic          core_read_i,
  output logic [DW-1:0] core_rdata_o,
  output logic          core_stall_o,
  input  logic          host_valid_i,
  output logic          host_ready_o,
  input  logic          host_write_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [DW-1:0] host_wdata_i,
  output logic          host_rvalid_o,
  input  logic          host_rready_i,
  output logic [DW-1:0] host_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_write_o,
  input  logic [DW-1:0] mem_rdata_i
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          idle, core_acc, starved, grant, rd_grant, resp_done;
  always_comb begin
    idle         = state_q == ST_IDLE;
    core_acc     = core_read_i | core_write_i;
    starved      = starve_q == CW'(STARVE_LIMIT);
    host_ready_o = idle & (!core_acc | starved);
    grant        = host_ready_o & host_valid_i;
    rd_grant     = grant & !host_write_i;
    resp_done    = rvalid_q & host_rready_i;
    core_stall_o = grant & core_acc;
    mem_addr_o   = grant ? host_addr_i : core_addr_i;
    mem_wdata_o  = grant ? host_wdata_i : core_wdata_i;
    mem_write_o  = grant ? host_write_i : core_write_i & !core_stall_o;
    core_rdata_o = mem_rdata_i;
    state_d      = rd_grant ? ST_RESP : resp_done ? ST_IDLE : state_q;
    rvalid_d     = rd_grant | (rvalid_q & !host_rready_i);
    rdata_d      = rd_grant ? mem_rdata_i : rdata_q;
    // a waiting host is counted only in IDLE; the count is frozen during a response
    starve_d     = (grant | !host_valid_i) ? '0 :
                   (idle & !starved) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end
  assign host_rvalid_o = rvalid_q;
  assign host_rdata_o  = rdata_q;
endmodule

// File: tb/tb_d_memory_arbiter.sv
// tb_d_memory_arbiter: directed stimulus with a behavioural arbiter/memory model checked every cycle
module tb_d_memory_arbiter;
  localparam int LIMIT = 8;
  logic        clk = 0, rst = 1;
  logic [31:0] core_addr = 0, core_wdata = 0, host_addr = 0, host_wdata = 0;
  logic        core_write = 0, core_read = 0, host_valid = 0, host_write = 0, host_rready = 0;
  logic [31:0] core_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        core_stall, host_ready, host_rvalid, mem_write;
  logic [31:0] dmem [0:63];
  logic [31:0] mmem [0:63];
  int          n_chk = 0, n_fail = 0;
  bit          m_on = 0, m_resp = 0;
  int          m_wait = 0;
  logic [31:0] m_rdata = 0;

  always #5 clk = ~clk;

  d_memory_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_write_i(core_write),
    .core_read_i(core_read), .core_rdata_o(core_rdata), .core_stall_o(core_stall),
    .host_valid_i(host_valid), .host_ready_o(host_ready), .host_write_i(host_write),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata), .host_rvalid_o(host_rvalid),
    .host_rready_i(host_rready), .host_rdata_o(host_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_write_o(mem_write),
    .mem_rdata_i(mem_rdata)
  );

  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) dmem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: host served when core idle or after LIMIT waiting cycles; one outstanding read.
  always @(negedge clk) begin
    bit          acc, e_ready, e_grant, e_stall, e_write;
    logic [31:0] e_addr, e_wdata;
    if (m_on) begin
      acc     = core_read || core_write;
      e_ready = !m_resp && (!acc || m_wait >= LIMIT);
      e_grant = e_ready && host_valid;
      e_stall = e_grant && acc;
      e_addr  = e_grant ? host_addr : core_addr;
      e_wdata = e_grant ? host_wdata : core_wdata;
      e_write = e_grant ? host_write : (core_write && !e_stall);
      chk("host_ready", {31'b0, host_ready}, {31'b0, e_ready});
      chk("core_stall", {31'b0, core_stall}, {31'b0, e_stall});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_write", {31'b0, mem_write}, {31'b0, e_write});
      if (e_write) chk("mem_wdata", mem_wdata, e_wdata);
      chk("core_rdata", core_rdata, mmem[e_addr[7:2]]);
      chk("host_rvalid", {31'b0, host_rvalid}, {31'b0, m_resp});
      chk("host_rdata", host_rdata, m_rdata);
      if (rst) begin
        m_resp = 0; m_wait = 0; m_rdata = 0;
      end else begin
        if (e_grant && !host_write) begin
          m_resp  = 1;
          m_rdata = mmem[host_addr[7:2]];
        end else if (m_resp && host_rready) m_resp = 0;
        if (e_write) mmem[e_addr[7:2]] = e_wdata;
        if (e_grant || !host_valid) m_wait = 0;
        else if (!m_resp && !e_grant && m_wait < LIMIT) m_wait = m_wait + 1;
      end
    end else if (rst) begin
      m_on = 1; m_resp = 0; m_wait = 0; m_rdata = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int stalls[$];
    for (int i = 0; i < 64; i++) begin
      dmem[i] = 32'h1000 + i;
      mmem[i] = 32'h1000 + i;
    end
    // 1: reset
    step(); step();
    rst = 0;
    #1;
    chk("rst_rvalid", {31'b0, host_rvalid}, 32'd0);
    chk("rst_stall", {31'b0, core_stall}, 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    // 2: host write while core idle
    host_valid = 1; host_write = 1; host_addr = 8; host_wdata = 32'hDEADBEEF;
    #1;
    chk("hw_ready", {31'b0, host_ready}, 32'd1);
    chk("hw_mem_write", {31'b0, mem_write}, 32'd1);
    step();
    host_valid = 0; host_write = 0;
    chk("hw_mem8", dmem[2], 32'hDEADBEEF);
    // 3: host read with delayed consumption
    host_valid = 1; host_addr = 8;
    step();
    host_valid = 0;
    chk("hr_rvalid", {31'b0, host_rvalid}, 32'd1);
    chk("hr_rdata", host_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hr_hold_rvalid", {31'b0, host_rvalid}, 32'd1);
      chk("hr_hold_rdata", host_rdata, 32'hDEADBEEF);
      chk("hr_hold_ready", {31'b0, host_ready}, 32'd0);
    end
    host_rready = 1;
    step();
    host_rready = 0;
    chk("hr_done", {31'b0, host_rvalid}, 32'd0);
    // 4: core loads every cycle, host write forced every LIMIT+1 cycles
    core_read = 1; core_addr = 32'h20;
    host_valid = 1; host_write = 1; host_addr = 32'h40; host_wdata = 32'h55;
    for (int c = 0; c < 27; c++) begin
      #1;
      if (core_stall) stalls.push_back(c);
      step();
    end
    chk("starve_nstall", stalls.size(), 32'd3);
    if (stalls.size() == 3) begin
      chk("starve_first", stalls[0], 32'd8);
      chk("starve_gap1", stalls[1] - stalls[0], 32'd9);
      chk("starve_gap2", stalls[2] - stalls[1], 32'd9);
    end
    host_valid = 0; host_write = 0; core_read = 0;
    step();
    // 5: forced host write collides with a core store
    core_read = 1; core_addr = 32'h20;
    host_valid = 1; host_write = 1; host_addr = 32'h64; host_wdata = 32'hF00D;
    for (int c = 0; c < LIMIT; c++) step();
    core_read = 0; core_write = 1; core_addr = 32'h60; core_wdata = 32'hC0DE;
    #1;
    chk("fw_stall", {31'b0, core_stall}, 32'd1);
    chk("fw_addr", mem_addr, 32'h64);
    chk("fw_wdata", mem_wdata, 32'hF00D);
    step();
    host_valid = 0; host_write = 0;
    chk("fw_host_mem", dmem[25], 32'hF00D);
    chk("fw_core_not_yet", dmem[24], 32'h1018);
    step();
    core_write = 0;
    chk("fw_core_mem", dmem[24], 32'hC0DE);
    // 6: reset during a pending response
    host_valid = 1; host_addr = 32'h64;
    step();
    host_valid = 0;
    chk("rr_rvalid", {31'b0, host_rvalid}, 32'd1);
    chk("rr_rdata", host_rdata, 32'hF00D);
    rst = 1;
    step();
    #1;
    chk("rr_rst_rvalid", {31'b0, host_rvalid}, 32'd0);
    chk("rr_rst_ready", {31'b0, host_ready}, 32'd1);
    rst = 0;
    step();
    host_valid = 1; host_addr = 32'h60;
    step();
    host_valid = 0; host_rready = 1;
    chk("post_rdata", host_rdata, 32'hC0DE);
    step();
    host_rready = 0;
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
